// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a carry flop resolve
// one bit per clock. Result is {carry_out, sum bits} with a one-cycle done.
module serial_adder #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             s_bit;

  // Carry-out of a full adder: set when at least two inputs are set.
  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Next-state, datapath update and completion capture.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    s_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new request on its only edge so back-to-back
        // operations cost WIDTH+1 cycles each.
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = carry_in;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        carry_d = majority(a_sh_q[0], b_sh_q[0], carry_q);
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        r_sh_d  = {s_bit, r_sh_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          sum_d   = {carry_d, r_sh_d};
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

  // Status decode straight from the registered state.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    sum  = sum_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: transaction-level reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_serial_adder;

  localparam int WIDTH = 5;
  localparam int CNT_W = 3;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             cin   = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   sum;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  serial_adder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .carry_in (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum)
  );

  always #5 clk = ~clk;

  // Reference model: an accepted request produces a+b+cin exactly WIDTH
  // edges later; m_left counts edges still owed to the operation in flight.
  int             m_left;
  logic           m_done;
  logic [WIDTH:0] m_sum;
  logic [WIDTH:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_res  <= '0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) m_sum <= m_res;
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_res  <= (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);
        m_left <= WIDTH;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", 32'(busy), 32'(m_left != 0));
      check("model_done", 32'(done), 32'(m_done));
      check("model_sum",  32'(sum),  32'(m_sum));
      check("busy_done_excl", 32'(busy & done), 32'd0);
    end
  end

  // Counts edges from the current point until done is seen; bounded.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 20);
  endtask

  // Single start pulse, then checks latency, result and the done pulse width.
  task automatic run_op(input string name, input logic [WIDTH-1:0] av,
                        input logic [WIDTH-1:0] bv, input logic cv,
                        input logic [WIDTH:0] exp);
    int n;
    @(negedge clk);
    start = 1'b1; a = av; b = bv; cin = cv;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    check({name, "_latency"}, 32'(n), 32'(WIDTH));
    check({name, "_sum"}, 32'(sum), 32'(exp));
    @(posedge clk);
    #1;
    check({name, "_done_fall"}, 32'(done), 32'd0);
    check({name, "_sum_hold"}, 32'(sum), 32'(exp));
  endtask

  initial begin
    int n;
    logic [WIDTH-1:0] ra, rb;
    logic rc;

    // Reset state
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum",  32'(sum),  32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    run_op("alt_bits", 5'b10101, 5'b01010, 1'b0, 6'b011111);
    run_op("small",    5'b00011, 5'b01010, 1'b0, 6'b001101);
    repeat (3) @(posedge clk);
    #1 check("small_idle_hold", 32'(sum), 32'd13);
    run_op("ripple",   5'b11111, 5'b00001, 1'b0, 6'b100000);
    run_op("all_ones", 5'b11111, 5'b11111, 1'b1, 6'b111111);

    // Back-to-back with start held high
    @(negedge clk);
    start = 1'b1; a = 5'b00100; b = 5'b01011; cin = 1'b0;
    @(posedge clk);
    wait_done(n);
    check("b2b_first_latency", 32'(n), 32'(WIDTH));
    check("b2b_first_sum", 32'(sum), 32'd15);
    for (int k = 0; k < 2; k++) begin
      wait_done(n);
      check("b2b_period", 32'(n), 32'(WIDTH + 1));
      check("b2b_sum", 32'(sum), 32'd15);
    end
    start = 1'b0;
    @(posedge clk);
    #1 check("b2b_stop_busy", 32'(busy), 32'd0);

    // Start and operands disturbed during RUN are ignored
    @(negedge clk);
    start = 1'b1; a = 5'b00110; b = 5'b01001; cin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 begin start = 1'b1; a = 5'b11111; b = 5'b11111; cin = 1'b1; end
    @(posedge clk);
    #1 begin start = 1'b0; a = 5'b00000; b = 5'b00000; cin = 1'b0; end
    wait_done(n);
    check("ignore_latency", 32'(n), 32'(WIDTH - 2));
    check("ignore_sum", 32'(sum), 32'd15);

    // Asynchronous reset in the third RUN cycle
    @(negedge clk);
    start = 1'b1; a = 5'b00011; b = 5'b00101; cin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_sum",  32'(sum),  32'd0);
    #1 rst_n = 1'b1;
    run_op("post_reset", 5'b00001, 5'b00001, 1'b1, 6'b000011);

    // Randomised sweep against plain arithmetic
    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      run_op("sweep", ra, rb, rc, (WIDTH+1)'(ra) + (WIDTH+1)'(rb) + (WIDTH+1)'(rc));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder: the addition-direction counterpart of the team's ripple full-subtractor datapath.
- Latches two operands and a carry-in on a start strobe, then resolves one bit per clock through a single full-adder cell and a carry flip-flop.
- Presents a (WIDTH+1)-bit result, with the final carry-out as MSB, together with a one-cycle done pulse.
- Sits beside the subtractor in the ALU as an area-cheap adder for multi-cycle operations.

Parameters:
WIDTH, 5, operand width in bits; must be >= 2.
CNT_W, 3, width of the internal bit counter; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active-low
start  input  1  request; sampled only when the block is not busy
a  input  WIDTH  augend, sampled on the accepted start edge
b  input  WIDTH  addend, sampled on the accepted start edge
carry_in  input  1  initial carry, sampled on the accepted start edge
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH+1  result {carry_out, sum bits}; held until next completion

Behaviour:
- Reset:
  - rst_n low asynchronously forces state=IDLE, busy=0, done=0, sum=0, carry FF=0, counter=0 and clears the operand shift registers.
  - Reset applies at any time, including mid-RUN. The partial result is discarded and sum reads 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - On a clock edge with start=1: load a_sh<=a, b_sh<=b, carry<=carry_in, cnt<=0, then go to RUN.
- RUN, each edge:
  - s_bit = a_sh[0] ^ b_sh[0] ^ carry.
  - carry <= majority(a_sh[0], b_sh[0], carry).
  - Shift a_sh and b_sh right by 1. Shift s_bit into the internal result register r_sh from the MSB end.
  - cnt <= cnt+1.
  - On the edge where cnt == WIDTH-1: write sum <= {carry_next, r_sh_next} and go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0.
  - On the next edge: if start=1, accept new operands exactly as in IDLE and go to RUN (back-to-back allowed); otherwise go to IDLE.
- Latency:
  - start accepted at edge E.
  - sum is updated and done rises at edge E+WIDTH.
  - done falls at edge E+WIDTH+1.
  - Throughput: one result per WIDTH+1 cycles.
- start while busy=1 is ignored. It is neither queued nor does it corrupt the operation. Operand input changes during RUN have no effect.
- sum holds its last value through IDLE and RUN and changes only on the completion edge or on reset.
- Arithmetic:
  - sum = a + b + carry_in, unsigned, modulo 2**(WIDTH+1).
  - The result never truncates, because the maximum value (2*(2**WIDTH - 1) + 1) fits in WIDTH+1 bits.
- done and busy are never both high.

Test Plan:
- Reset, then a=10101, b=01010, carry_in=0, start pulsed 1 cycle -> busy high for 5 cycles; done pulses at start edge+5; sum=011111 (31).
- a=00011, b=01010, carry_in=0 -> sum=001101 (13), done exactly one cycle, sum stable afterwards through IDLE.
- Carry ripple: a=11111, b=00001, carry_in=0 -> sum=100000. Then a=11111, b=11111, carry_in=1 -> sum=111111 (63).
- start held high continuously with a=00100, b=01011 -> results 001111 (15) every 6 cycles, each run re-latching operands in the DONE cycle; start and a/b toggled during RUN -> ignored, result unchanged.
- rst_n driven low asynchronously (between clock edges) in the 3rd RUN cycle -> busy, done and sum go to 0 immediately without a clock edge. After release, a fresh start with a=00001, b=00001, carry_in=1 -> sum=000011.
- Exhaustive or randomised a, b, carry_in sweep against the reference model a+b+carry_in -> all results match, with latency exactly WIDTH edges from accept to done.
